// File: rtl/mdu_hilo_pkg.sv
// Shared encodings for the multiply/divide unit. The controller and the hazard
// unit import this package so that everyone agrees on the md_op values.
package mdu_hilo_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_RSV6  = 3'd6,
    MD_RSV7  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit holding HI/LO. Results are computed when the
// request is accepted and held in pending registers until the busy window ends.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Handshake: a request is taken on a rising edge where start=1 and busy=0;
  // while busy=1 every request is dropped and the requester must stall.

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_div0;

  md_op_e      w_op;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic        w_div0;
  logic        w_ovf;
  logic [31:0] w_divisor;
  logic [31:0] w_quo_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quo_u;
  logic [31:0] w_rem_u;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_op = md_op_e'(md_op);

  // The low 64 bits of a product of sign-extended operands equal the signed product.
  assign w_prod_s = {{32{in1[31]}}, in1} * {{32{in2[31]}}, in2};
  assign w_prod_u = {32'd0, in1} * {32'd0, in2};

  // A zero divisor is replaced by 1 so the divider never sees it; the commit is suppressed.
  assign w_div0    = (in2 == 32'd0);
  assign w_divisor = w_div0 ? 32'd1 : in2;
  assign w_ovf     = (in1 == 32'h8000_0000) && (in2 == 32'hFFFF_FFFF);

  assign w_quo_s = w_ovf ? 32'h8000_0000 : $unsigned($signed(in1) / $signed(w_divisor));
  assign w_rem_s = w_ovf ? 32'd0         : $unsigned($signed(in1) % $signed(w_divisor));
  assign w_quo_u = in1 / w_divisor;
  assign w_rem_u = in1 % w_divisor;

  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (w_op)
      MD_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
      MD_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
      MD_DIV:   begin w_res_hi = w_rem_s; w_res_lo = w_quo_s; end
      MD_DIVU:  begin w_res_hi = w_rem_u; w_res_lo = w_quo_u; end
      default:  begin w_res_hi = 32'd0;   w_res_lo = 32'd0;   end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_div0    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (w_op)
              MD_MULT, MD_MULTU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_div0    <= 1'b0;
                r_cnt     <= CNT_W'(MULT_CYCLES);
                r_state   <= ST_BUSY;
              end
              MD_DIV, MD_DIVU: begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_div0    <= w_div0;
                r_cnt     <= CNT_W'(DIV_CYCLES);
                r_state   <= ST_BUSY;
              end
              MD_MTHI: r_hi <= in1;
              MD_MTLO: r_lo <= in1;
              default: ;
            endcase
          end
        end
        ST_BUSY: begin
          if (r_cnt == CNT_W'(1)) begin
            if (!r_div0) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_BUSY);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: directed scenarios plus random traffic, every cycle
// compared against an arithmetic reference model with a pending-result queue.
module tb_mdu_hilo;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: {div_by_zero, hi, lo} of the operation in flight.
  logic [64:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_left;

  mdu_hilo #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Signed division from magnitudes: quotient toward zero, remainder follows dividend.
  function automatic logic [63:0] ref_sdiv(input logic [31:0] a, input logic [31:0] b);
    int    ia, ib;
    longint sa, sb, ma, mb, q, r;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    q  = ma / mb;
    r  = ma % mb;
    if ((sa < 0) != (sb < 0)) q = -q;
    if (sa < 0) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [64:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, p;
    int     ia, ib;
    logic [63:0] u;
    ia = a; ib = b; sa = ia; sb = ib;
    case (op)
      3'd0: begin p = sa * sb; return {1'b0, p[63:0]}; end
      3'd1: begin u = {32'd0, a} * {32'd0, b}; return {1'b0, u}; end
      3'd2: return (b == 0) ? {1'b1, 64'd0} : {1'b0, ref_sdiv(a, b)};
      default: return (b == 0) ? {1'b1, 64'd0} : {1'b0, b == 0 ? 32'd0 : a % b, b == 0 ? 32'd0 : a / b};
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic s, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    logic [64:0] e;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_left = 0;
      exp_q.delete();
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        e = exp_q.pop_front();
        if (!e[64]) begin m_hi = e[63:32]; m_lo = e[31:0]; end
      end
    end else if (s) begin
      case (op)
        3'd0, 3'd1: begin exp_q.push_back(ref_result(op, a, b)); m_left = MULT_N; end
        3'd2, 3'd3: begin exp_q.push_back(ref_result(op, a, b)); m_left = DIV_N; end
        3'd4: m_hi = a;
        3'd5: m_lo = a;
        default: ;
      endcase
    end
  endtask

  // Driver: apply one cycle of inputs, advance model, compare outputs after the edge.
  task automatic tick(input logic rst, input logic s, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    reset = rst; start = s; md_op = op; in1 = a; in2 = b;
    @(posedge clk);
    model_edge(rst, s, op, a, b);
    #1;
    check_eq("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    check_eq("hi", hi, m_hi);
    check_eq("lo", lo, m_lo);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 3'd0, $urandom, $urandom);
  endtask

  // Issue one op and idle until busy drops; returns the number of busy cycles seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n_busy);
    tick(1'b0, 1'b1, op, a, b);
    n_busy = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      n_busy++;
      tick(1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
    end
  endtask

  initial begin
    int nb;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; md_op = 3'd0; in1 = 32'd0; in2 = 32'd0;
    m_hi = 0; m_lo = 0; m_left = 0;
    tick(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    tick(1'b1, 1'b1, 3'd4, 32'hDEAD, 32'd0);
    check_eq("rst_hi", hi, 32'd0);

    // 1. signed multiply
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, nb);
    check_eq("mult_busy_len", nb, MULT_N);
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFFA);
    // 2. unsigned multiply
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
    check_eq("multu_hi", hi, 32'hFFFF_FFFE);
    check_eq("multu_lo", lo, 32'h0000_0001);
    // 3. divides
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, nb);
    check_eq("div_busy_len", nb, DIV_N);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);
    run_op(3'd3, 32'd7, 32'd2, nb);
    check_eq("divu_lo", lo, 32'd3);
    check_eq("divu_hi", hi, 32'd1);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb);
    check_eq("div_ovf_lo", lo, 32'h8000_0000);
    check_eq("div_ovf_hi", hi, 32'd0);
    // 4. MTHI immediate; MTLO during busy dropped
    tick(1'b0, 1'b1, 3'd4, 32'h1234, 32'd0);
    check_eq("mthi_hi", hi, 32'h1234);
    check_eq("mthi_busy", {31'd0, busy}, 32'd0);
    tick(1'b0, 1'b1, 3'd0, 32'd3, 32'd4);
    tick(1'b0, 1'b1, 3'd5, 32'd1, 32'd0);
    for (int i = 0; i < MULT_N; i++) idle();
    check_eq("mtlo_busy_lo", lo, 32'd12);
    // 5. divide by zero leaves HI/LO alone
    tick(1'b0, 1'b1, 3'd4, 32'hAAAA, 32'd0);
    tick(1'b0, 1'b1, 3'd5, 32'h5555, 32'd0);
    run_op(3'd2, 32'd99, 32'd0, nb);
    check_eq("div0_busy_len", nb, DIV_N);
    check_eq("div0_hi", hi, 32'hAAAA);
    check_eq("div0_lo", lo, 32'h5555);
    // 6. reset aborts a divide, then back-to-back multiplies
    tick(1'b0, 1'b1, 3'd3, 32'd100, 32'd7);
    idle(); idle();
    tick(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_lo", lo, 32'd0);
    for (int i = 0; i < DIV_N; i++) idle();
    check_eq("abort_nocommit", lo, 32'd0);
    run_op(3'd1, 32'd6, 32'd7, nb);
    run_op(3'd1, 32'd11, 32'd13, nb);
    check_eq("b2b_busy_len", nb, MULT_N);
    check_eq("b2b_lo", lo, 32'd143);

    // Random traffic with biased corner operands
    for (int i = 0; i < 600; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        3: a = -32'($urandom_range(1, 50));
        default: ;
      endcase
      tick(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) != 0),
           3'($urandom_range(0, 7)), a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
